// File: rtl/framebuffer_swap_controller.sv
// Double-buffer sequencer: steers renderer writes to the back bank,
// presents the front bank to the display and flips on frame boundaries.
module framebuffer_swap_controller #(
    parameter int HOR_ACTIVE_PIXELS = 640,
    parameter int VER_ACTIVE_PIXELS = 480,
    parameter int FRAME_DIV         = 1,
    parameter int MISS_WIDTH        = 8,
    localparam int ADDR_WIDTH =
        $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  render_done,
    input  logic                  frame_start,
    input  logic                  in_wr_en,
    input  logic [ADDR_WIDTH-1:0] in_wr_addr,
    input  logic                  in_wr_data,
    output logic                  swap,
    output logic                  bank0_wr_en,
    output logic                  bank1_wr_en,
    output logic [ADDR_WIDTH-1:0] bank_wr_addr,
    output logic                  bank_wr_data,
    input  logic                  bank0_rd_data,
    input  logic                  bank1_rd_data,
    output logic                  rd_data,
    output logic                  front_sel,
    output logic [MISS_WIDTH-1:0] missed_frames,
    output logic                  wr_violation
);

    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

    typedef enum logic [1:0] {
        HOLDOFF,
        RENDER,
        WAIT_VBLANK,
        FLIP
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [DIV_W-1:0] div_cnt;
    logic             div_hit;
    logic             miss_inc;
    logic             wr_fwd;
    logic             rd_sel_q;

    assign div_hit = frame_start && (div_cnt == DIV_LAST);
    assign wr_fwd  = (state == RENDER) && in_wr_en;

    // Select is registered so it tracks the one-cycle BRAM read latency
    assign rd_data = rd_sel_q ? bank1_rd_data : bank0_rd_data;

    always_comb begin
        state_d  = state;
        miss_inc = 1'b0;
        swap     = 1'b0;
        unique case (state)
            HOLDOFF: begin
                if (!render_done) state_d = RENDER;
            end
            RENDER: begin
                if (render_done && div_hit) state_d = FLIP;
                else if (render_done)       state_d = WAIT_VBLANK;
                else if (div_hit)           miss_inc = 1'b1;
            end
            WAIT_VBLANK: begin
                if (div_hit) state_d = FLIP;
            end
            FLIP: begin
                swap    = 1'b1;
                state_d = HOLDOFF;
            end
            default: state_d = HOLDOFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= HOLDOFF;
            div_cnt       <= '0;
            front_sel     <= 1'b0;
            rd_sel_q      <= 1'b0;
            missed_frames <= '0;
            wr_violation  <= 1'b0;
            bank0_wr_en   <= 1'b0;
            bank1_wr_en   <= 1'b0;
            bank_wr_addr  <= '0;
            bank_wr_data  <= 1'b0;
        end else begin
            state    <= state_d;
            rd_sel_q <= front_sel;
            if (frame_start)
                div_cnt <= div_hit ? '0 : div_cnt + 1'b1;
            // FLIP never self-loops, so this toggles exactly once per flip
            if (state_d == FLIP && state != FLIP)
                front_sel <= ~front_sel;
            if (miss_inc && missed_frames != '1)
                missed_frames <= missed_frames + 1'b1;
            if (in_wr_en && state != RENDER)
                wr_violation <= 1'b1;
            bank0_wr_en <= wr_fwd && front_sel;
            bank1_wr_en <= wr_fwd && !front_sel;
            if (wr_fwd) begin
                bank_wr_addr <= in_wr_addr;
                bank_wr_data <= in_wr_data;
            end
        end
    end

endmodule

// File: tb/tb_framebuffer_swap_controller.sv
// Directed bench for framebuffer_swap_controller (FRAME_DIV=1 and
// FRAME_DIV=3 instances driven from the same stimulus).
module tb_framebuffer_swap_controller;

    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          render_done = 1'b0;
    logic          frame_start = 1'b0;
    logic          in_wr_en = 1'b0;
    logic [AW-1:0] in_wr_addr = '0;
    logic          in_wr_data = 1'b0;
    logic          bank0_rd_data = 1'b0;
    logic          bank1_rd_data = 1'b1;

    logic          swap, b0_we, b1_we, wr_data_o, rd_data, front_sel, wr_viol;
    logic [AW-1:0] wr_addr_o;
    logic [7:0]    missed;

    logic          swap3, b0_we3, b1_we3, wr_data_o3, rd_data3, front_sel3;
    logic          wr_viol3;
    logic [AW-1:0] wr_addr_o3;
    logic [7:0]    missed3;

    int checks = 0;
    int failures = 0;
    int swaps = 0;
    int swaps3 = 0;

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (swap === 1'b1) swaps++;
        if (swap3 === 1'b1) swaps3++;
    end

    framebuffer_swap_controller #(.FRAME_DIV(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .render_done(render_done), .frame_start(frame_start),
        .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr),
        .in_wr_data(in_wr_data), .swap(swap),
        .bank0_wr_en(b0_we), .bank1_wr_en(b1_we),
        .bank_wr_addr(wr_addr_o), .bank_wr_data(wr_data_o),
        .bank0_rd_data(bank0_rd_data), .bank1_rd_data(bank1_rd_data),
        .rd_data(rd_data), .front_sel(front_sel),
        .missed_frames(missed), .wr_violation(wr_viol)
    );

    framebuffer_swap_controller #(.FRAME_DIV(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .render_done(render_done), .frame_start(frame_start),
        .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr),
        .in_wr_data(in_wr_data), .swap(swap3),
        .bank0_wr_en(b0_we3), .bank1_wr_en(b1_we3),
        .bank_wr_addr(wr_addr_o3), .bank_wr_data(wr_data_o3),
        .bank0_rd_data(bank0_rd_data), .bank1_rd_data(bank1_rd_data),
        .rd_data(rd_data3), .front_sel(front_sel3),
        .missed_frames(missed3), .wr_violation(wr_viol3)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
    endtask

    initial begin
        // Reset values
        #12;
        check("rst_swap", swap, 0);
        check("rst_front", front_sel, 0);
        check("rst_b0we", b0_we, 0);
        check("rst_b1we", b1_we, 0);
        check("rst_missed", missed, 0);
        check("rst_viol", wr_viol, 0);
        check("rst_rd", rd_data, 0);
        rst_n = 1'b1;
        tick();
        tick();

        // Misses while rendering
        repeat (3) pulse_fs();
        check("miss3", missed, 3);
        check("noswap", swaps, 0);
        check("front0", front_sel, 0);

        // Write to back bank 1
        in_wr_addr = 19'd1234;
        in_wr_data = 1'b1;
        in_wr_en   = 1'b1;
        tick();
        in_wr_en = 1'b0;
        check("wr_b1we", b1_we, 1);
        check("wr_b0we", b0_we, 0);
        check("wr_addr", wr_addr_o, 1234);
        check("wr_data", wr_data_o, 1);
        tick();
        check("wr_b1we_off", b1_we, 0);

        // Done, frame_start five cycles later
        render_done = 1'b1;
        tick();
        repeat (4) tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        render_done = 1'b0;
        check("flip_swap", swap, 1);
        check("flip_front", front_sel, 1);
        tick();
        check("swap_off", swap, 0);
        check("swap_cnt", swaps, 1);
        check("rd_front1", rd_data, 1);
        tick();
        in_wr_addr = 19'd77;
        in_wr_data = 1'b0;
        in_wr_en   = 1'b1;
        tick();
        in_wr_en = 1'b0;
        check("wr2_b0we", b0_we, 1);
        check("wr2_b1we", b1_we, 0);
        check("wr2_addr", wr_addr_o, 77);
        check("wr2_data", wr_data_o, 0);
        check("viol_none", wr_viol, 0);

        // Done and frame_start together
        render_done = 1'b1;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("same_swap", swap, 1);
        check("same_front", front_sel, 0);
        check("same_miss", missed, 3);
        tick();
        tick();
        render_done = 1'b0;
        tick();
        render_done = 1'b1;
        tick();
        in_wr_addr = 19'd5;
        in_wr_en   = 1'b1;
        tick();
        in_wr_en = 1'b0;
        check("viol_b0we", b0_we, 0);
        check("viol_b1we", b1_we, 0);
        check("viol_set", wr_viol, 1);
        tick();
        check("viol_sticky", wr_viol, 1);

        // Asynchronous reset mid-WAIT_VBLANK
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_viol", wr_viol, 0);
        check("arst_miss", missed, 0);
        check("arst_addr", wr_addr_o, 0);
        check("arst_front", front_sel, 0);
        check("arst_swap", swap, 0);
        render_done = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        // Saturation
        repeat (255) pulse_fs();
        check("sat255", missed, 255);
        pulse_fs();
        check("sat_hold", missed, 255);

        // FRAME_DIV=3 instance
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        swaps3 = 0;
        for (int k = 0; k < 6; k++) begin
            render_done = 1'b0;
            tick();
            tick();
            render_done = 1'b1;
            tick();
            tick();
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            check($sformatf("div3_swap%0d", k), swap3,
                  (k % 3 == 2) ? 1 : 0);
            tick();
            check($sformatf("div3_off%0d", k), swap3, 0);
        end
        check("div3_cnt", swaps3, 2);
        check("div3_miss", missed3, 0);
        check("div3_front", front_sel3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
